bist_datapath: RTL and testbench

Memory-side datapath for the march-test BIST engine. It consumes the command strobes issued by the BIST `control` FSM (`enable`, `up_down`, `rst_adr`, `pr_res_adr`, `wr_en`, `read_en`, `data_bit`) and drives the memory under test. It returns terminal-count (`c_out`) and mismatch (`error`) to the FSM. Internally it holds the address counter, the write-data generator, a one-stage read-compare pipeline and first-failure diagnostic capture.

---
 rtl/bist_datapath.sv | 124 ++++++++++++
 tb/tb_bist_datapath.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_datapath.sv
// March-test BIST memory-side datapath: address counter, background data,
// one-stage read-compare pipeline and first-failure diagnostic capture.
module bist_datapath #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          up_down,
  input  logic          rst_adr,
  input  logic          pr_res_adr,
  input  logic          wr_en,
  input  logic          read_en,
  input  logic          data_bit,
  output logic          c_out,
  output logic          error,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] fail_addr,
  output logic [DW-1:0] fail_data,
  output logic [CW-1:0] fail_count
);

  localparam logic [AW-1:0] MAXA  = '1;
  localparam logic [AW-1:0] A_ONE = AW'(1);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  logic [AW-1:0] addr_q, addr_d;
  logic          rd_vld_q, rd_vld_d;
  logic [DW-1:0] exp_q, exp_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          err_sticky_q, err_sticky_d;
  logic [AW-1:0] fail_addr_q, fail_addr_d;
  logic [DW-1:0] fail_data_q, fail_data_d;
  logic [CW-1:0] fail_count_q, fail_count_d;

  logic          test_clr;
  logic          mism;

  // rst_adr alone marks the FSM leaving standby; with wr_en it is only the
  // wr_down -> read_up address turnaround and must keep the diagnostics.
  assign test_clr  = rst_adr & ~wr_en & ~read_en;
  assign mism      = rd_vld_q & (mem_rdata != exp_q);

  assign mem_addr  = addr_q;
  assign mem_wdata = {DW{data_bit}};
  assign mem_we    = wr_en & enable;
  assign mem_re    = read_en & enable & ~wr_en;
  assign c_out     = enable & ((up_down & (addr_q == MAXA)) | (~up_down & (addr_q == '0)));
  assign error     = err_sticky_q | mism;

  assign fail_addr  = fail_addr_q;
  assign fail_data  = fail_data_q;
  assign fail_count = fail_count_q;

  always_comb begin
    addr_d = addr_q;
    if (rst_adr) begin
      addr_d = '0;
    end else if (pr_res_adr) begin
      addr_d = MAXA;
    end else if (enable) begin
      addr_d = up_down ? addr_q + A_ONE : addr_q - A_ONE;
    end
  end

  always_comb begin
    rd_vld_d     = mem_re;
    exp_d        = {DW{data_bit}};
    rd_addr_d    = addr_q;
    err_sticky_d = err_sticky_q;
    fail_addr_d  = fail_addr_q;
    fail_data_d  = fail_data_q;
    fail_count_d = fail_count_q;
    if (mism) begin
      err_sticky_d = 1'b1;
      if (!err_sticky_q) begin
        fail_addr_d = rd_addr_q;
        fail_data_d = mem_rdata ^ exp_q;
      end
      if (fail_count_q != '1) begin
        fail_count_d = fail_count_q + C_ONE;
      end
    end
    // A test-start clear overrides a mismatch arriving in the same cycle.
    if (test_clr) begin
      rd_vld_d     = 1'b0;
      exp_d        = '0;
      rd_addr_d    = '0;
      err_sticky_d = 1'b0;
      fail_addr_d  = '0;
      fail_data_d  = '0;
      fail_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q       <= '0;
      rd_vld_q     <= 1'b0;
      exp_q        <= '0;
      rd_addr_q    <= '0;
      err_sticky_q <= 1'b0;
      fail_addr_q  <= '0;
      fail_data_q  <= '0;
      fail_count_q <= '0;
    end else begin
      addr_q       <= addr_d;
      rd_vld_q     <= rd_vld_d;
      exp_q        <= exp_d;
      rd_addr_q    <= rd_addr_d;
      err_sticky_q <= err_sticky_d;
      fail_addr_q  <= fail_addr_d;
      fail_data_q  <= fail_data_d;
      fail_count_q <= fail_count_d;
    end
  end

endmodule

// File: tb/tb_bist_datapath.sv
// Bench for bist_datapath: march sequences against a faulty-memory model,
// checked every cycle against a behavioural reference plus literal checkpoints.
module tb_bist_datapath;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, enable = 1'b0, up_down = 1'b0, rst_adr = 1'b0, pr_res_adr = 1'b0;
  logic wr_en = 1'b0, read_en = 1'b0, data_bit = 1'b0;
  logic c_out, error, mem_we, mem_re;
  logic [3:0] mem_addr, fail_addr;
  logic [7:0] mem_wdata, fail_data, fail_count;
  logic [7:0] mem_rdata = 8'h00;

  logic d2_c_out, d2_error, d2_we, d2_re;
  logic [3:0] d2_addr, d2_faddr;
  logic [7:0] d2_wdata, d2_fdata;
  logic [1:0] d2_count;

  bist_datapath #(.AW(4), .DW(8), .CW(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .rst_adr(rst_adr),
    .pr_res_adr(pr_res_adr), .wr_en(wr_en), .read_en(read_en), .data_bit(data_bit),
    .c_out(c_out), .error(error), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .fail_addr(fail_addr), .fail_data(fail_data), .fail_count(fail_count));

  bist_datapath #(.AW(4), .DW(8), .CW(2)) dut2 (
    .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .rst_adr(rst_adr),
    .pr_res_adr(pr_res_adr), .wr_en(wr_en), .read_en(read_en), .data_bit(data_bit),
    .c_out(d2_c_out), .error(d2_error), .mem_addr(d2_addr), .mem_wdata(d2_wdata),
    .mem_we(d2_we), .mem_re(d2_re), .mem_rdata(mem_rdata),
    .fail_addr(d2_faddr), .fail_data(d2_fdata), .fail_count(d2_count));

  // Memory under test with stuck-at masks, driven by the DUT's own strobes.
  logic [7:0] mem [16];
  logic [7:0] sa1 [16];
  logic [7:0] sa0 [16];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= (mem[mem_addr] | sa1[mem_addr]) & ~sa0[mem_addr];
  end

  // Reference model: its own copy of memory contents and test diagnostics.
  logic [7:0] mm [16];
  logic [3:0] m_addr = 4'd0;
  logic       p_v = 1'b0, m_st = 1'b0;
  logic [7:0] p_exp = 8'h00, p_data = 8'h00;
  logic [3:0] p_addr = 4'd0, m_fa = 4'd0;
  logic [7:0] m_fd = 8'h00;
  int         m_cnt = 0, m_cnt2 = 0;

  always @(posedge clk) begin
    logic lm;
    logic [7:0] pat;
    lm  = p_v && (p_data != p_exp);
    pat = {8{data_bit}};
    if (rst) begin
      m_addr = 4'd0; p_v = 1'b0; m_st = 1'b0; m_fa = 4'd0; m_fd = 8'h00;
      m_cnt = 0; m_cnt2 = 0;
    end else begin
      if (rst_adr && !wr_en && !read_en) begin
        m_st = 1'b0; m_fa = 4'd0; m_fd = 8'h00; m_cnt = 0; m_cnt2 = 0; p_v = 1'b0;
      end else begin
        if (lm) begin
          if (!m_st) begin m_fa = p_addr; m_fd = p_data ^ p_exp; end
          m_st = 1'b1;
          if (m_cnt < 255) m_cnt++;
          if (m_cnt2 < 3) m_cnt2++;
        end
        p_v    = read_en && enable && !wr_en;
        p_exp  = pat;
        p_addr = m_addr;
        p_data = (mm[m_addr] | sa1[m_addr]) & ~sa0[m_addr];
      end
      if (wr_en && enable) mm[m_addr] = pat;
      if (rst_adr) m_addr = 4'd0;
      else if (pr_res_adr) m_addr = 4'd15;
      else if (enable) m_addr = up_down ? m_addr + 4'd1 : m_addr - 4'd1;
    end
  end

  int total = 0, bad = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      chk("c_out", 32'(c_out),
          32'(enable && ((up_down && m_addr == 4'd15) || (!up_down && m_addr == 4'd0))));
      chk("mem_we", 32'(mem_we), 32'(wr_en && enable));
      chk("mem_re", 32'(mem_re), 32'(read_en && enable && !wr_en));
      chk("mem_wdata", 32'(mem_wdata), 32'({8{data_bit}}));
      chk("error", 32'(error), 32'(m_st || (p_v && p_data != p_exp)));
      chk("fail_addr", 32'(fail_addr), 32'(m_fa));
      chk("fail_data", 32'(fail_data), 32'(m_fd));
      chk("fail_count", 32'(fail_count), 32'(m_cnt));
      chk("d2_error", 32'(d2_error), 32'(m_st || (p_v && p_data != p_exp)));
      chk("d2_count", 32'(d2_count), 32'(m_cnt2));
    end
  end

  task automatic drive(input logic r, input logic en, input logic ud, input logic ra,
                       input logic pr, input logic we, input logic re, input logic db);
    @(posedge clk); #1;
    rst = r; enable = en; up_down = ud; rst_adr = ra; pr_res_adr = pr;
    wr_en = we; read_en = re; data_bit = db;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // FSM-like march: w(bg) up, r(bg) down, w(~bg) down, r(~bg) up.
  task automatic march(input logic bg, input int ab_ph, input int ab_a,
                       output int pulses, output logic err_sb);
    logic up, wr, db, ra, pr;
    int a;
    pulses = 0;
    err_sb = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int ph = 0; ph < 4; ph++) begin
      up = (ph == 0 || ph == 3);
      wr = (ph == 0 || ph == 2);
      db = (ph < 2) ? bg : ~bg;
      for (int i = 0; i < 16; i++) begin
        a  = up ? i : 15 - i;
        ra = (ph == 2 && i == 15);
        pr = (ph < 2 && i == 15);
        if (ph == ab_ph && a == ab_a) begin
          drive(1'b1, 1'b1, up, ra, pr, wr, !wr, db);
          drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
          chk("abort_addr", 32'(mem_addr), 32'd0);
          chk("abort_error", 32'(error), 32'd0);
          chk("abort_we", 32'(mem_we), 32'd0);
          idle();
          return;
        end
        drive(1'b0, 1'b1, up, ra, pr, wr, !wr, db);
        if (c_out) pulses++;
        if (ph == 0 && i == 0) begin
          chk("start_error", 32'(error), 32'd0);
          chk("start_count", 32'(fail_count), 32'd0);
        end
      end
    end
    idle();
    err_sb = error;
  endtask

  initial begin
    int pulses;
    logic esb;
    for (int i = 0; i < 16; i++) begin
      mem[i] = 8'h00; mm[i] = 8'h00; sa1[i] = 8'h00; sa0[i] = 8'h00;
    end

    // Reset state
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_count", 32'(fail_count), 32'd0);
    chk("rst_c_out", 32'(c_out), 32'd0);
    idle();

    // Fault-free march
    march(1'b0, -1, -1, pulses, esb);
    chk("clean_pulses", 32'(pulses), 32'd4);
    chk("clean_error", 32'(esb), 32'd0);
    chk("clean_count", 32'(fail_count), 32'd0);

    // Gated and conflicting strobes, then clear coinciding with a live mismatch
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("gated_we", 32'(mem_we), 32'd0);
    chk("gated_re", 32'(mem_re), 32'd0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("both_we", 32'(mem_we), 32'd1);
    chk("both_re", 32'(mem_re), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("probe_re", 32'(mem_re), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("live_mism", 32'(error), 32'd1);
    idle();
    chk("clr_wins_error", 32'(error), 32'd0);
    chk("clr_wins_count", 32'(fail_count), 32'd0);

    // Word 5 bit 3 stuck-at-1: caught in read_down
    sa1[5] = 8'h08;
    march(1'b0, -1, -1, pulses, esb);
    chk("sa1_error", 32'(esb), 32'd1);
    chk("sa1_faddr", 32'(fail_addr), 32'd5);
    chk("sa1_fdata", 32'(fail_data), 32'h08);
    chk("sa1_count", 32'(fail_count), 32'd1);

    // Word 15 bit 0 stuck-at-0: only the last read_up read sees it
    sa1[5] = 8'h00;
    sa0[15] = 8'h01;
    march(1'b0, -1, -1, pulses, esb);
    chk("last_read_error", 32'(esb), 32'd1);
    idle();
    chk("last_faddr", 32'(fail_addr), 32'd15);
    chk("last_fdata", 32'(fail_data), 32'h01);
    chk("last_count", 32'(fail_count), 32'd1);

    // All cells stuck-at-0, inverted background: 2-bit counter saturates
    for (int i = 0; i < 16; i++) sa0[i] = 8'hFF;
    march(1'b1, -1, -1, pulses, esb);
    chk("sat_d2_count", 32'(d2_count), 32'd3);
    chk("sat_count", 32'(fail_count), 32'd16);
    chk("sat_faddr", 32'(fail_addr), 32'd15);
    chk("sat_fdata", 32'(fail_data), 32'hFF);
    chk("sat_d2_faddr", 32'(d2_faddr), 32'd15);

    // Reset mid wr_down at address 9, then a clean pass
    for (int i = 0; i < 16; i++) sa0[i] = 8'h00;
    sa1[5] = 8'h08;
    march(1'b0, 2, 9, pulses, esb);
    sa1[5] = 8'h00;
    march(1'b0, -1, -1, pulses, esb);
    chk("post_rst_pulses", 32'(pulses), 32'd4);
    chk("post_rst_error", 32'(esb), 32'd0);
    chk("post_rst_count", 32'(fail_count), 32'd0);

    idle();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
